alu_seq: RTL and testbench
==========================

// Module: alu_seq
// PURPOSE
//  Parametrised, handshaked successor to the combinational integer ALU.
//  - Single-cycle registered base ops.
//  - Iterative RV M-extension ops: multiply by shift-add, divide by restoring division.
//  - Sits between the decode/issue stage and writeback; stalls issue through in_ready.
// PARAMETERS
//  XLEN  32  operand/result width; power of two, >= 8
//  OPW   5   op code width; must be 5
// PORTS
//  clk        in   1     clock; all logic on rising edge
//  rst        in   1     synchronous, active-high reset
//  flush      in   1     abort any op in flight; discard the held result
//  in_valid   in   1     op/in1/in2 valid
//  in_ready   out  1     unit can accept an op
//  op         in   OPW   operation code (encoding below)
//  in1        in   XLEN  operand 1 (rs1)
//  in2        in   XLEN  operand 2 (rs2/imm)
//  out_valid  out  1     result valid
//  out_ready  in   1     consumer takes the result
//  out        out  XLEN  result
// BEHAVIOUR
//  Op codes:
//   - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 LT, 9 LTU.
//   - 16 MUL, 17 MULH, 18 MULHSU, 19 MULHU, 20 DIV, 21 DIVU, 22 REM, 23 REMU.
//   - Any other code: result 0, treated as a base op.
//  Arithmetic rules:
//   - Shifts use in2[$clog2(XLEN)-1:0] only.
//   - LT/LTU: out = {XLEN-1 zeros, compare bit}.
//   - Add/sub wrap modulo 2^XLEN.
//   - MUL returns low XLEN bits of the 2*XLEN product; MULH* return the high XLEN bits.
//   - MULH: both operands signed; MULHSU: in1 signed, in2 unsigned.
//   - Divide by zero: DIV/DIVU -> all ones; REM/REMU -> in1.
//   - Signed overflow (in1 = MIN, in2 = -1): DIV -> MIN; REM -> 0.
//   - Signed div/rem: divide magnitudes, then fix signs. Quotient sign = sign(in1) ^ sign(in2); remainder sign = sign(in1).
//  State machine, states IDLE, BUSY, DONE:
//   - IDLE: in_ready = 1. Accept on in_valid & in_ready & !flush.
//     - Base op: register the result -> DONE.
//     - M op: latch operands and flags, load counter = XLEN -> BUSY.
//     - Div-by-zero or overflow: register the special result -> DONE (1-cycle).
//   - BUSY: one multiply or divide step per cycle; counter decrements. Counter reaches 0 -> DONE, with the sign fix applied on that transition.
//   - DONE: out_valid = 1; out and out_valid held stable until out_ready.
//     - out_ready -> IDLE.
//     - No same-cycle accept: in_ready = 0 outside IDLE.
//  Latency, accept at edge N:
//   - Base or special op: out_valid from cycle N+1.
//   - Iterative op: out_valid from cycle N+XLEN+1.
//   - Throughput: at most one op per 2 cycles.
//  Reset values: in_ready = 1 (state IDLE), out_valid = 0, out = 0. Counter, operand and partial registers = 0.
//  flush: in any state -> IDLE next cycle, out_valid = 0.
//   - flush with in_valid in the same cycle: flush wins, the op is not accepted.
//   - flush in DONE together with out_ready: result dropped; the consumer must ignore it.
//  rst mid-operation: same as flush, and registers are zeroed.
//  in_valid with in_ready = 0: ignored. The producer must hold op and operands stable.
//  out is undefined when out_valid = 0; the bench must not check it.
// CONFIGURATION
//  ALU_SEQ_MDU_EN:
//   - Defined: full M-extension datapath as above.
//   - Undefined:
//     - Ops 16-23 behave as unknown codes (result 0, 1-cycle).
//     - BUSY state, counter and partial registers are not built.
//     - Handshake and latency of base ops are unchanged.
// TESTING
//  1 ADD 0xFFFFFFFF+1 -> out_valid at N+1, out=0. SRA 0x80000000, in2=0x24 -> 0xF8000000.
//  2 MULHSU in1=-2, in2=3 -> 0xFFFFFFFF at N+33. MULH 0x80000000^2 -> 0x40000000.
//  3 DIV 7/0 -> 0xFFFFFFFF at N+1. REM MIN/-1 -> 0. DIVU 100/7 -> 14 at N+33. REM -7/2 -> 0xFFFFFFFF (-1).
//  4 Hold out_ready=0 for 5 cycles in DONE -> out stable, in_ready=0. Release -> in_ready=1 next cycle.
//  5 flush at cycle N+10 of a DIV -> out_valid never rises; IDLE at N+11; a new ADD is accepted normally.
//  6 rst asserted in BUSY -> next cycle out_valid=0, in_ready=1. Build without ALU_SEQ_MDU_EN -> MUL returns 0 at N+1.

Source files
------------

// File: rtl/alu_seq.sv
// ============================================================================
//  Module      : alu_seq
//  Description : Handshaked integer ALU. Base ops complete in one cycle.
//                With ALU_SEQ_MDU_EN defined, the RV M-extension ops run
//                iteratively: shift-add multiply and restoring divide.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_seq #(
    parameter int XLEN = 32,
    parameter int OPW  = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [OPW-1:0]  op,
    input  logic [XLEN-1:0] in1,
    input  logic [XLEN-1:0] in2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out
);
    localparam int c_SHW = $clog2(XLEN);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
`ifdef ALU_SEQ_MDU_EN
        S_BUSY = 2'd2,
`endif
        S_DONE = 2'd1
    } state_t;

    state_t          r_state;
    logic            r_in_ready;
    logic            r_out_valid;
    logic [XLEN-1:0] r_out;
    logic [XLEN-1:0] w_base;
    logic [c_SHW-1:0] w_sh;

    assign w_sh = in2[c_SHW-1:0];

    always_comb begin
        w_base = '0;
        case (op)
            5'd0:    w_base = in1 + in2;
            5'd1:    w_base = in1 - in2;
            5'd2:    w_base = in1 & in2;
            5'd3:    w_base = in1 | in2;
            5'd4:    w_base = in1 ^ in2;
            5'd5:    w_base = in1 << w_sh;
            5'd6:    w_base = in1 >> w_sh;
            5'd7:    w_base = $signed(in1) >>> w_sh;
            5'd8:    w_base = {{(XLEN-1){1'b0}}, ($signed(in1) < $signed(in2))};
            5'd9:    w_base = {{(XLEN-1){1'b0}}, (in1 < in2)};
            default: w_base = '0;
        endcase
    end

`ifdef ALU_SEQ_MDU_EN
    localparam int c_CW = c_SHW + 1;
    localparam logic [XLEN-1:0] c_MIN = {1'b1, {(XLEN-1){1'b0}}};

    logic            w_is_m, w_is_div, w_sgn1, w_sgn2, w_n1, w_n2, w_dz, w_ovf, w_spec;
    logic [XLEN-1:0] w_abs1, w_abs2, w_special;
    logic [XLEN:0]   w_add, w_sub;
    logic [XLEN-1:0] w_hi_n, w_lo_n, w_res;
    logic [2*XLEN-1:0] w_prod;

    logic [XLEN-1:0] r_hi, r_lo, r_b;
    logic [c_CW-1:0] r_cnt;
    logic            r_div, r_sel_hi, r_neg;

    assign w_is_m    = (op[4:3] == 2'b10);
    assign w_is_div  = w_is_m & op[2];
    assign w_sgn1    = (op == 5'd17) | (op == 5'd18) | (op == 5'd20) | (op == 5'd22);
    assign w_sgn2    = (op == 5'd17) | (op == 5'd20) | (op == 5'd22);
    assign w_n1      = w_sgn1 & in1[XLEN-1];
    assign w_n2      = w_sgn2 & in2[XLEN-1];
    assign w_abs1    = w_n1 ? (~in1 + 1'b1) : in1;
    assign w_abs2    = w_n2 ? (~in2 + 1'b1) : in2;
    assign w_dz      = w_is_div & (in2 == '0);
    assign w_ovf     = w_is_div & w_sgn1 & (in1 == c_MIN) & (in2 == '1);
    assign w_spec    = w_dz | w_ovf;
    // op[1] selects REM/REMU within the divide group
    assign w_special = w_dz ? (op[1] ? in1 : '1) : (op[1] ? '0 : c_MIN);

    // One iteration: r_lo holds the multiplier or the dividend/quotient,
    // r_hi the upper product half or the running remainder.
    always_comb begin
        w_add = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
        w_sub = {r_hi, r_lo[XLEN-1]} - {1'b0, r_b};
        if (r_div) begin
            if (!w_sub[XLEN]) begin
                w_hi_n = w_sub[XLEN-1:0];
                w_lo_n = {r_lo[XLEN-2:0], 1'b1};
            end else begin
                w_hi_n = {r_hi[XLEN-2:0], r_lo[XLEN-1]};
                w_lo_n = {r_lo[XLEN-2:0], 1'b0};
            end
        end else begin
            w_hi_n = w_add[XLEN:1];
            w_lo_n = {w_add[0], r_lo[XLEN-1:1]};
        end
        w_prod = {w_hi_n, w_lo_n};
        if (r_neg) w_prod = ~w_prod + 1'b1;
        if (r_div) begin
            if (r_sel_hi) w_res = r_neg ? (~w_hi_n + 1'b1) : w_hi_n;
            else          w_res = r_neg ? (~w_lo_n + 1'b1) : w_lo_n;
        end else begin
            w_res = r_sel_hi ? w_prod[2*XLEN-1:XLEN] : w_prod[XLEN-1:0];
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out       <= '0;
`ifdef ALU_SEQ_MDU_EN
            r_hi     <= '0;
            r_lo     <= '0;
            r_b      <= '0;
            r_cnt    <= '0;
            r_div    <= 1'b0;
            r_sel_hi <= 1'b0;
            r_neg    <= 1'b0;
`endif
        end else if (flush) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_in_ready <= 1'b0;
`ifdef ALU_SEQ_MDU_EN
                        if (w_is_m && !w_spec) begin
                            r_state  <= S_BUSY;
                            r_hi     <= '0;
                            r_lo     <= w_is_div ? w_abs1 : w_abs2;
                            r_b      <= w_is_div ? w_abs2 : w_abs1;
                            r_cnt    <= c_CW'(XLEN);
                            r_div    <= w_is_div;
                            r_sel_hi <= w_is_div ? op[1] : (op[1:0] != 2'b00);
                            r_neg    <= (w_is_div && op[1]) ? w_n1 : (w_n1 ^ w_n2);
                        end else begin
                            r_state     <= S_DONE;
                            r_out_valid <= 1'b1;
                            r_out       <= w_is_m ? w_special : w_base;
                        end
`else
                        r_state     <= S_DONE;
                        r_out_valid <= 1'b1;
                        r_out       <= w_base;
`endif
                    end
                end
`ifdef ALU_SEQ_MDU_EN
                S_BUSY: begin
                    r_hi  <= w_hi_n;
                    r_lo  <= w_lo_n;
                    r_cnt <= r_cnt - c_CW'(1);
                    if (r_cnt == c_CW'(1)) begin
                        r_state     <= S_DONE;
                        r_out_valid <= 1'b1;
                        r_out       <= w_res;
                    end
                end
`endif
                S_DONE: begin
                    if (out_ready) begin
                        r_state     <= S_IDLE;
                        r_in_ready  <= 1'b1;
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out       = r_out;

endmodule

`default_nettype wire

// File: tb/tb_alu_seq.sv
// ============================================================================
//  Module      : tb_alu_seq
//  Description : Directed self-checking bench for alu_seq.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_seq;
    localparam int XLEN = 32;

    logic            clk;
    logic            rst;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [4:0]      op;
    logic [XLEN-1:0] in1;
    logic [XLEN-1:0] in2;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out;

    int checks = 0;
    int errors = 0;

    alu_seq #(.XLEN(XLEN), .OPW(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .in1       (in1),
        .in2       (in2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Present an op for one edge; the unit is expected to be idle.
    task automatic start_op(input string tag, input logic [4:0] o, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        @(negedge clk);
        check({tag, "_rdy"}, {31'd0, in_ready}, 32'd1);
        op = o; in1 = a; in2 = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Latency counted so that "valid in the cycle after the accept edge" is 1.
    task automatic wait_result(output logic [XLEN-1:0] res, output int lat);
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        res = out;
    endtask

    task automatic run_op(input string tag, input logic [4:0] o, input logic [XLEN-1:0] a,
                          input logic [XLEN-1:0] b, input logic [XLEN-1:0] exp, input int exp_lat);
        logic [XLEN-1:0] res;
        int lat;
        start_op(tag, o, a, b);
        wait_result(res, lat);
        check({tag, "_lat"}, XLEN'(lat), XLEN'(exp_lat));
        check(tag, res, exp);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [XLEN-1:0] res;
        int lat;
        int seen;

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        op = '0; in1 = '0; in2 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out", out, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op("add_wrap", 5'd0,  32'hFFFF_FFFF, 32'h1,         32'h0,         1);
        run_op("sra",      5'd7,  32'h8000_0000, 32'h24,        32'hF800_0000, 1);
        run_op("sub",      5'd1,  32'd5,         32'd7,         32'hFFFF_FFFE, 1);
        run_op("slt",      5'd8,  32'hFFFF_FFFF, 32'd1,         32'd1,         1);
        run_op("sltu",     5'd9,  32'hFFFF_FFFF, 32'd1,         32'd0,         1);
        run_op("xor",      5'd4,  32'hF0F0_1234, 32'h0FF0_1200, 32'hFF00_0034, 1);
        run_op("srl",      5'd6,  32'h8000_0000, 32'h21,        32'h4000_0000, 1);
        run_op("unknown",  5'd12, 32'h1234_5678, 32'h1,         32'h0,         1);

`ifdef ALU_SEQ_MDU_EN
        run_op("mulhsu",   5'd18, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 33);
        run_op("mulh",     5'd17, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
        run_op("mul",      5'd16, 32'd7,         32'd6,         32'd42,        33);
        run_op("mulhu",    5'd19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        run_op("div_z",    5'd20, 32'd7,         32'd0,         32'hFFFF_FFFF, 1);
        run_op("remu_z",   5'd23, 32'd5,         32'd0,         32'd5,         1);
        run_op("rem_ovf",  5'd22, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);
        run_op("div_ovf",  5'd20, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op("divu",     5'd21, 32'd100,       32'd7,         32'd14,        33);
        run_op("rem_neg",  5'd22, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33);
        run_op("div_neg",  5'd20, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33);
`else
        run_op("mul_off",  5'd16, 32'd7,         32'd6,         32'd0,         1);
        run_op("div_off",  5'd20, 32'd7,         32'd0,         32'd0,         1);
`endif

        // Back-pressure: result and in_ready held while out_ready is low.
        out_ready = 1'b0;
        start_op("hold", 5'd0, 32'd1, 32'd2);
        wait_result(res, lat);
        check("hold_lat", XLEN'(lat), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("hold_out", out, 32'd3);
            check("hold_valid", {31'd0, out_valid}, 32'd1);
            check("hold_in_ready", {31'd0, in_ready}, 32'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("release_in_ready", {31'd0, in_ready}, 32'd1);
        check("release_valid", {31'd0, out_valid}, 32'd0);

        // flush presented together with an op: the op is dropped.
        @(negedge clk);
        op = 5'd0; in1 = 32'd9; in2 = 32'd9; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (out_valid) seen = 1;
            @(posedge clk); #1;
        end
        check("flush_accept", XLEN'(seen), 32'd0);
        check("flush_accept_rdy", {31'd0, in_ready}, 32'd1);

`ifdef ALU_SEQ_MDU_EN
        // flush part-way through a divide.
        start_op("fdiv", 5'd21, 32'd1000, 32'd3);
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_idle", {31'd0, in_ready}, 32'd1);
        check("flush_valid", {31'd0, out_valid}, 32'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) seen = 1;
            @(posedge clk); #1;
        end
        check("flush_no_result", XLEN'(seen), 32'd0);
        run_op("post_flush_add", 5'd0, 32'd2, 32'd3, 32'd5, 1);

        // reset while busy.
        start_op("rmul", 5'd16, 32'd3, 32'd5);
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_busy_valid", {31'd0, out_valid}, 32'd0);
        check("rst_busy_rdy", {31'd0, in_ready}, 32'd1);
        check("rst_busy_out", out, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op("post_rst_mul", 5'd16, 32'd3, 32'd5, 32'd15, 33);
`else
        run_op("post_flush_add", 5'd0, 32'd2, 32'd3, 32'd5, 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
